// File: rtl/sel_mux.sv
// Parameterized N:1 word selector with a combinational output, an enabled
// registered copy and an out-of-range select flag.
module sel_mux #(
    parameter int NUM_INPUTS   = 8,
    parameter int WIDTH_INPUTS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_INPUTS-1:0][WIDTH_INPUTS-1:0]  in,
    input  logic [$clog2(NUM_INPUTS)-1:0]            sel,
    input  logic                                     en,
    output logic [WIDTH_INPUTS-1:0]                  out,
    output logic [WIDTH_INPUTS-1:0]                  out_q,
    output logic                                     sel_err
);

    localparam int SEL_W = $clog2(NUM_INPUTS);
    localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_INPUTS);

    logic [WIDTH_INPUTS-1:0] mux_word;
    logic [WIDTH_INPUTS-1:0] out_q_d;

    // AND-OR selection: an out-of-range index matches no source and yields zero.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            mux_word = mux_word | (in[i] & {WIDTH_INPUTS{sel == SEL_W'(i)}});
        end
    end

    assign out     = mux_word;
    assign sel_err = ({1'b0, sel} >= NUM_L);

    always_comb begin
        out_q_d = out_q;
        if (en) begin
            out_q_d = mux_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_q_d;
        end
    end

endmodule

// File: tb/tb_sel_mux.sv
// Directed and randomized checks of sel_mux in an 8x4 and a 6x8 configuration
// against a table-lookup reference model.
module tb_sel_mux;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 8 x 4-bit instance (power-of-two source count)
    logic [7:0][3:0] in_a;
    logic [2:0]      sel_a;
    logic            en_a;
    logic [3:0]      out_a;
    logic [3:0]      out_q_a;
    logic            err_a;

    // 6 x 8-bit instance (out-of-range selects possible)
    logic [5:0][7:0] in_b;
    logic [2:0]      sel_b;
    logic            en_b;
    logic [7:0]      out_b;
    logic [7:0]      out_q_b;
    logic            err_b;

    sel_mux #(.NUM_INPUTS(8), .WIDTH_INPUTS(4)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .sel(sel_a), .en(en_a),
        .out(out_a), .out_q(out_q_a), .sel_err(err_a)
    );

    sel_mux #(.NUM_INPUTS(6), .WIDTH_INPUTS(8)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .sel(sel_b), .en(en_b),
        .out(out_b), .out_q(out_q_b), .sel_err(err_b)
    );

    // Reference model state
    logic [3:0] words_a [8];
    logic [7:0] words_b [6];
    logic [3:0] exp_q_a;
    logic [7:0] exp_q_b;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    function automatic logic [3:0] refA(input int s);
        return (s < 8) ? words_a[s] : 4'h0;
    endfunction

    function automatic logic [7:0] refB(input int s);
        return (s < 6) ? words_b[s] : 8'h00;
    endfunction

    function automatic logic refErrB(input int s);
        return (s >= 6);
    endfunction

    task automatic applyStimulus(input logic [2:0] sa, input logic ea,
                                 input logic [2:0] sb, input logic eb);
        for (int i = 0; i < 8; i++) in_a[i] = words_a[i];
        for (int i = 0; i < 6; i++) in_b[i] = words_b[i];
        sel_a = sa;
        en_a  = ea;
        sel_b = sb;
        en_b  = eb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, update the register model, then check both copies.
    task automatic clockAndCheck(input string tag);
        @(posedge clk);
        if (rst) begin
            exp_q_a = '0;
            exp_q_b = '0;
        end else begin
            if (en_a) exp_q_a = refA(int'(sel_a));
            if (en_b) exp_q_b = refB(int'(sel_b));
        end
        #1;
        checkOutput({tag, "_qa"}, 32'(out_q_a), 32'(exp_q_a));
        checkOutput({tag, "_qb"}, 32'(out_q_b), 32'(exp_q_b));
    endtask

    task automatic checkComb(input string tag);
        checkOutput({tag, "_outa"}, 32'(out_a), 32'(refA(int'(sel_a))));
        checkOutput({tag, "_erra"}, 32'(err_a), 32'(1'b0));
        checkOutput({tag, "_outb"}, 32'(out_b), 32'(refB(int'(sel_b))));
        checkOutput({tag, "_errb"}, 32'(err_b), 32'(refErrB(int'(sel_b))));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) words_a[i] = 4'(i);
        for (int i = 0; i < 6; i++) words_b[i] = 8'hA0 + 8'(i);
        exp_q_a = '0;
        exp_q_b = '0;
        rst = 1'b1;
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0);
        #12;
        checkOutput("reset_qa", 32'(out_q_a), 32'h0);
        checkOutput("reset_qb", 32'(out_q_b), 32'h0);
        checkComb("reset_comb");
        @(negedge clk);
        rst = 1'b0;

        // Combinational sweep, 10 ns settle per select
        for (int s = 0; s < 8; s++) begin
            applyStimulus(3'(s), 1'b0, 3'd0, 1'b0);
            #10;
            checkOutput("sweep_out", 32'(out_a), 32'(s));
            checkOutput("sweep_err", 32'(err_a), 32'h0);
        end

        // Registered stage: one-edge latency
        @(negedge clk);
        applyStimulus(3'd3, 1'b1, 3'd0, 1'b0);
        clockAndCheck("load3");
        checkOutput("load3_val", 32'(out_q_a), 32'd3);
        @(negedge clk);
        applyStimulus(3'd5, 1'b1, 3'd0, 1'b0);
        clockAndCheck("load5");
        checkOutput("load5_val", 32'(out_q_a), 32'd5);

        // Asynchronous reset between edges, held across an edge
        #2;
        rst = 1'b1;
        #1;
        exp_q_a = '0;
        exp_q_b = '0;
        checkOutput("async_rst_qa", 32'(out_q_a), 32'h0);
        checkOutput("async_rst_out", 32'(out_a), 32'd5);
        clockAndCheck("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        clockAndCheck("reload");
        checkOutput("reload_val", 32'(out_q_a), 32'd5);

        // Hold with en = 0
        @(negedge clk);
        applyStimulus(3'd3, 1'b1, 3'd0, 1'b0);
        clockAndCheck("pre_hold");
        @(negedge clk);
        applyStimulus(3'd6, 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            clockAndCheck("hold");
            checkOutput("hold_qa", 32'(out_q_a), 32'd3);
            checkOutput("hold_out", 32'(out_a), 32'd6);
        end

        // 6-input instance: in-range and out-of-range selects
        @(negedge clk);
        applyStimulus(3'd0, 1'b0, 3'd5, 1'b1);
        #1;
        checkOutput("b5_out", 32'(out_b), 32'hA5);
        checkOutput("b5_err", 32'(err_b), 32'h0);
        clockAndCheck("b5");
        for (int s = 6; s < 8; s++) begin
            @(negedge clk);
            applyStimulus(3'd0, 1'b0, 3'(s), 1'b1);
            #1;
            checkOutput("boor_out", 32'(out_b), 32'h00);
            checkOutput("boor_err", 32'(err_b), 32'h1);
            clockAndCheck("boor");
            checkOutput("boor_q", 32'(out_q_b), 32'h00);
        end

        // Input change with no clock edge
        @(negedge clk);
        applyStimulus(3'd0, 1'b0, 3'd2, 1'b1);
        clockAndCheck("b2");
        @(negedge clk);
        en_b = 1'b0;
        words_b[2] = 8'h5C;
        applyStimulus(3'd0, 1'b0, 3'd2, 1'b0);
        #1;
        checkOutput("b2_live_out", 32'(out_b), 32'h5C);
        checkOutput("b2_live_q", 32'(out_q_b), 32'hA2);
        clockAndCheck("b2_noen");
        @(negedge clk);
        applyStimulus(3'd0, 1'b0, 3'd2, 1'b1);
        clockAndCheck("b2_en");
        checkOutput("b2_en_val", 32'(out_q_b), 32'h5C);

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) words_a[i] = 4'($urandom);
            for (int i = 0; i < 6; i++) words_b[i] = 8'($urandom);
            applyStimulus(3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
            rst = ($urandom_range(0, 15) == 0);
            #1;
            checkComb("rand");
            if (rst) begin
                exp_q_a = '0;
                exp_q_b = '0;
                checkOutput("rand_rst_qa", 32'(out_q_a), 32'h0);
                checkOutput("rand_rst_qb", 32'(out_q_b), 32'h0);
            end
            clockAndCheck("rand");
        end
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
